conv_maxpool_2x2: RTL and testbench

- Streaming 2x2 stride-2 max-pool stage directly downstream of the 3x3 convolution blocks.
- Consumes the conv output stream: one fp32 pixel per valid cycle, raster order, one full output-channel plane after another.
- Emits the pooled plane stream, (W/2)x(H/2) per channel, same channel order, to the next layer.
- No backpressure; the downstream stage always accepts.

---
 rtl/conv_maxpool_2x2_pkg.sv | 19 +
 rtl/fp32_max2.sv | 12 +
 rtl/conv_maxpool_2x2.sv | 105 ++++++++++
 tb/tb_conv_maxpool_2x2.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/conv_maxpool_2x2_pkg.sv
// Shared helpers for the 2x2 max-pool stage: fp32 ordering key and clog2.
package conv_maxpool_2x2_pkg;

  localparam int unsigned FP32_W = 32;

  // At least 1 so degenerate sizes still yield a legal vector width.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction

  // Maps fp32 onto an unsigned total order: negatives reversed, positives above them.
  function automatic logic [FP32_W-1:0] fp32_key(input logic [FP32_W-1:0] x);
    return x[FP32_W-1] ? ~x : (x ^ 32'h8000_0000);
  endfunction

endpackage

// File: rtl/fp32_max2.sv
// Combinational fp32 max of two operands; the first operand wins ties.
module fp32_max2
  import conv_maxpool_2x2_pkg::*;
(
  input  logic [FP32_W-1:0] a,
  input  logic [FP32_W-1:0] b,
  output logic [FP32_W-1:0] y
);

  assign y = (fp32_key(b) > fp32_key(a)) ? b : a;

endmodule

// File: rtl/conv_maxpool_2x2.sv
// Streaming 2x2 stride-2 max-pool over raster-order fp32 channel planes.
module conv_maxpool_2x2
  import conv_maxpool_2x2_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned IMAGE_WIDTH  = 64,
  parameter int unsigned IMAGE_HEIGHT = 64,
  parameter int unsigned CHANNEL_NUM  = 256,
  localparam int unsigned CH_W        = clog2(CHANNEL_NUM)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] pxl_in,
  output logic [DATA_WIDTH-1:0] pxl_out,
  output logic                  valid_out,
  output logic [CH_W-1:0]       ch_idx_out,
  output logic                  frame_done
);

  localparam int unsigned COL_W    = clog2(IMAGE_WIDTH);
  localparam int unsigned ROW_W    = clog2(IMAGE_HEIGHT);
  localparam int unsigned LB_DEPTH = IMAGE_WIDTH / 2;
  localparam int unsigned LB_W     = clog2(LB_DEPTH);

  logic [COL_W-1:0]      col_q;
  logic [ROW_W-1:0]      row_q;
  logic [CH_W-1:0]       ch_q;
  logic [DATA_WIDTH-1:0] hold_q;
  logic [DATA_WIDTH-1:0] lb_q [LB_DEPTH];

  logic [DATA_WIDTH-1:0] pxl_out_q;
  logic                  valid_out_q;
  logic [CH_W-1:0]       ch_idx_out_q;
  logic                  frame_done_q;

  logic                  col_last, row_last, ch_last;
  logic                  lb_wr, emit;
  logic [LB_W-1:0]       lb_addr;
  logic [DATA_WIDTH-1:0] lb_rd, h_max, v_max;

  assign col_last = (col_q == COL_W'(IMAGE_WIDTH - 1));
  assign row_last = (row_q == ROW_W'(IMAGE_HEIGHT - 1));
  assign ch_last  = (ch_q == CH_W'(CHANNEL_NUM - 1));
  assign lb_addr  = LB_W'(col_q >> 1);
  assign lb_rd    = lb_q[lb_addr];
  assign lb_wr    = valid_in && col_q[0] && !row_q[0];
  assign emit     = valid_in && col_q[0] && row_q[0];

  // Horizontal pair first, then merge with the row above from the line buffer.
  fp32_max2 u_max_h (
    .a (hold_q),
    .b (pxl_in),
    .y (h_max)
  );

  fp32_max2 u_max_v (
    .a (lb_rd),
    .b (h_max),
    .y (v_max)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col_q  <= '0;
      row_q  <= '0;
      ch_q   <= '0;
      hold_q <= '0;
    end else if (valid_in) begin
      col_q <= col_last ? '0 : col_q + 1'b1;
      if (!col_q[0]) hold_q <= pxl_in;
      if (col_last) begin
        row_q <= row_last ? '0 : row_q + 1'b1;
        if (row_last) ch_q <= ch_last ? '0 : ch_q + 1'b1;
      end
    end
  end

  // Contents are don't-care after reset, so no reset branch.
  always_ff @(posedge clk) begin
    if (lb_wr) lb_q[lb_addr] <= h_max;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pxl_out_q    <= '0;
      valid_out_q  <= 1'b0;
      ch_idx_out_q <= '0;
      frame_done_q <= 1'b0;
    end else begin
      valid_out_q  <= emit;
      frame_done_q <= emit && col_last && row_last && ch_last;
      if (emit) begin
        pxl_out_q    <= v_max;
        ch_idx_out_q <= ch_q;
      end
    end
  end

  assign pxl_out    = pxl_out_q;
  assign valid_out  = valid_out_q;
  assign ch_idx_out = ch_idx_out_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_conv_maxpool_2x2.sv
// Randomized self-checking bench for conv_maxpool_2x2 against a frame-level reference model.
module tb_conv_maxpool_2x2;

  localparam int unsigned W = 4;
  localparam int unsigned H = 4;
  localparam int unsigned C = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_in;
  logic [31:0] pxl_in;
  logic [31:0] pxl_out;
  logic        valid_out;
  logic [0:0]  ch_idx_out;
  logic        frame_done;

  always #5 clk = ~clk;

  conv_maxpool_2x2 #(
    .DATA_WIDTH   (32),
    .IMAGE_WIDTH  (W),
    .IMAGE_HEIGHT (H),
    .CHANNEL_NUM  (C)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_in   (valid_in),
    .pxl_in     (pxl_in),
    .pxl_out    (pxl_out),
    .valid_out  (valid_out),
    .ch_idx_out (ch_idx_out),
    .frame_done (frame_done)
  );

  typedef struct {
    logic [31:0] data;
    int          ch;
    bit          fd;
    int          due;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          fd_seen  = 0;
  logic [31:0] frm [C][H][W];
  logic [31:0] ramp [16] = '{
    32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
    32'h40A00000, 32'h40C00000, 32'h40E00000, 32'h41000000,
    32'h41100000, 32'h41200000, 32'h41300000, 32'h41400000,
    32'h41500000, 32'h41600000, 32'h41700000, 32'h41800000
  };

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Real-number ordering of fp32 bit patterns: -0 just below +0, infinities at the ends.
  function automatic longint ord(input logic [31:0] x);
    return x[31] ? -longint'({1'b0, x[30:0]}) - 1 : longint'({1'b0, x[30:0]});
  endfunction

  function automatic logic [31:0] fmax(input logic [31:0] a, input logic [31:0] b);
    return (ord(b) > ord(a)) ? b : a;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!reset) begin
      if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        check_eq("valid_out", 32'(valid_out), 32'd1);
        check_eq("pxl_out", pxl_out, e.data);
        check_eq("ch_idx_out", 32'(ch_idx_out), 32'(e.ch));
        check_eq("frame_done", 32'(frame_done), 32'(e.fd));
      end else if (valid_out || frame_done) begin
        check_eq("spurious_out", 32'({valid_out, frame_done}), 32'd0);
      end
      if (frame_done) fd_seen++;
    end
  end

  task automatic fill_ramp_mixed();
    for (int r = 0; r < H; r++)
      for (int x = 0; x < W; x++) begin
        frm[0][r][x] = ramp[r*W + x];
        frm[1][r][x] = 32'h8000_0000 | $urandom();
      end
    frm[1][0][0] = 32'h8000_0000;  // -0.0
    frm[1][0][1] = 32'h0000_0000;  // +0.0
    frm[1][1][0] = 32'hC0A00000;   // -5.0
    frm[1][1][1] = 32'hC0E00000;   // -7.0
    frm[1][0][2] = 32'hC0400000;   // -3.0
    frm[1][0][3] = 32'hBF800000;   // -1.0
    frm[1][1][2] = 32'hC0000000;   // -2.0
    frm[1][1][3] = 32'hC0800000;   // -4.0
  endtask

  task automatic fill_random();
    for (int c = 0; c < C; c++)
      for (int r = 0; r < H; r++)
        for (int x = 0; x < W; x++) frm[c][r][x] = $urandom();
  endtask

  // Streams the first npix pixels of frm; enters at edge+1, returns at edge+1.
  task automatic drive_frame(input bit gaps, input int npix);
    int   k;
    exp_t e;
    k = 0;
    for (int c = 0; c < C; c++)
      for (int r = 0; r < H; r++)
        for (int x = 0; x < W; x++) begin
          if (k == npix) return;
          valid_in = 1'b1;
          pxl_in   = frm[c][r][x];
          @(posedge clk);
          #1;
          valid_in = 1'b0;
          k++;
          if ((r % 2 == 1) && (x % 2 == 1)) begin
            e.data = fmax(fmax(frm[c][r-1][x-1], frm[c][r-1][x]),
                          fmax(frm[c][r][x-1], frm[c][r][x]));
            e.ch   = c;
            e.fd   = (c == C - 1) && (r == H - 1) && (x == W - 1);
            e.due  = cyc;
            exp_q.push_back(e);
          end
          if (gaps)
            while ($urandom_range(1) == 0) begin
              @(posedge clk);
              #1;
            end
        end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_pxl_out"}, pxl_out, 32'd0);
    check_eq({tag, "_valid_out"}, 32'(valid_out), 32'd0);
    check_eq({tag, "_ch_idx_out"}, 32'(ch_idx_out), 32'd0);
    check_eq({tag, "_frame_done"}, 32'(frame_done), 32'd0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int fd_base;
    reset    = 1'b1;
    valid_in = 1'b0;
    pxl_in   = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    idle(1);

    // Ramp ch0 plus signed-zero / all-negative ch1, continuous then gapped.
    fill_ramp_mixed();
    drive_frame(1'b0, C * H * W);
    idle(3);
    drive_frame(1'b1, C * H * W);
    idle(3);

    // Back-to-back frames with no idle cycle between them.
    fd_base = fd_seen;
    fill_random();
    drive_frame(1'b0, C * H * W);
    fill_random();
    drive_frame(1'b0, C * H * W);
    idle(3);
    check_eq("b2b_frame_done_count", 32'(fd_seen - fd_base), 32'd2);

    // Abort after 9 pixels; a pixel presented alongside reset must be dropped.
    fill_ramp_mixed();
    drive_frame(1'b0, 9);
    reset    = 1'b1;
    valid_in = 1'b1;
    pxl_in   = 32'h7F00_1234;
    #1;
    check_reset_outputs("midrst_async");
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    idle(2);
    check_reset_outputs("midrst_hold");
    exp_q.delete();
    reset = 1'b0;
    idle(1);
    drive_frame(1'b0, C * H * W);
    idle(3);

    // Random data, random gaps.
    for (int f = 0; f < 20; f++) begin
      fill_random();
      drive_frame(1'(f % 2), C * H * W);
    end
    idle(4);
    check_eq("pending_expected", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
